// File: rtl/snapshot_restore_engine.sv
// snapshot_restore_engine: replays a captured register snapshot into the register file after a value misprediction
module snapshot_restore_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter int SKIP_R0 = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic recover_req,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] snap_regs,
  output logic recovery_done,
  input  logic recovery_done_ack,
  output logic rf_we,
  output logic [$clog2(NUM_REGS)-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic wb_block,
  output logic busy,
  output logic [CNT_WIDTH-1:0] restore_count
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] FIRST = AW'(SKIP_R0 != 0 ? 1 : 0);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, RESTORE, DONE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
  logic rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    snap_d = snap_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = recover_req ? CAPTURE : IDLE;
      CAPTURE: begin
        state_d = RESTORE;
        idx_d = FIRST;
        snap_d = snap_regs;
      end
      RESTORE: begin
        state_d = idx_q == LAST ? DONE : RESTORE;
        idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
        cnt_d = (idx_q == LAST && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      end
      DONE: state_d = recovery_done_ack ? RELEASE : DONE;
      RELEASE: state_d = recover_req ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
    // write port is registered from the next index so the first write lands the cycle after CAPTURE
    rf_we_d = state_d == RESTORE;
    rf_waddr_d = rf_we_d ? idx_d : '0;
    rf_wdata_d = rf_we_d ? snap_d[idx_d] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) snap_q <= snap_d;
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign restore_count = cnt_q;
  assign busy = state_q != IDLE;
  assign wb_block = state_q == CAPTURE || state_q == RESTORE || state_q == DONE;
  assign recovery_done = state_q == DONE;
endmodule
